// File: rtl/line_raster_stream.sv
// rtl/line_raster_stream.sv - Bresenham line rasteriser streaming one pixel per cycle.
// Pixel count is tracked with a down-counter so the walk never steps past the endpoint.
module line_raster_stream #(
  parameter int COORD_W   = 8,
  parameter bit SKIP_LAST = 1'b0
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               START,
  input  logic [COORD_W-1:0] X0,
  input  logic [COORD_W-1:0] Y0,
  input  logic [COORD_W-1:0] X1,
  input  logic [COORD_W-1:0] Y1,
  output logic               BUSY,
  output logic [COORD_W-1:0] PIX_X,
  output logic [COORD_W-1:0] PIX_Y,
  output logic               PIX_VALID,
  input  logic               PIX_READY,
  output logic               PIX_LAST,
  output logic               DONE
);

  localparam int DW = COORD_W + 1;
  localparam int EW = COORD_W + 2;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W-1:0] rem_q, rem_d;
  logic signed [DW-1:0] dx_q, dx_d, dy_q, dy_d;
  logic sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [EW-1:0] err_q, err_d;

  logic [COORD_W-1:0] adx, ady, amax;
  logic signed [EW:0]   e2, dx_e2, dy_e2;
  logic signed [EW-1:0] dx_e, dy_e, err_step;
  logic                 step_x, step_y;
  logic [COORD_W-1:0]   x_step, y_step;

  // x_q/y_q still hold the start point during SETUP
  assign adx  = (x1_q >= x_q) ? (x1_q - x_q) : (x_q - x1_q);
  assign ady  = (y1_q >= y_q) ? (y1_q - y_q) : (y_q - y1_q);
  assign amax = (adx >= ady) ? adx : ady;

  assign e2     = $signed({err_q, 1'b0});
  assign dx_e2  = $signed({{2{dx_q[DW-1]}}, dx_q});
  assign dy_e2  = $signed({{2{dy_q[DW-1]}}, dy_q});
  assign dx_e   = $signed({dx_q[DW-1], dx_q});
  assign dy_e   = $signed({dy_q[DW-1], dy_q});
  assign step_x = (e2 >= dy_e2);
  assign step_y = (e2 <= dx_e2);

  assign err_step = err_q + (step_x ? dy_e : '0) + (step_y ? dx_e : '0);
  assign x_step   = sx_neg_q ? (x_q - ONE) : (x_q + ONE);
  assign y_step   = sy_neg_q ? (y_q - ONE) : (y_q + ONE);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    rem_d    = rem_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          x_d     = X0;
          y_d     = Y0;
          x1_d    = X1;
          y1_d    = Y1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        dx_d     = $signed({1'b0, adx});
        dy_d     = -$signed({1'b0, ady});
        sx_neg_d = (x1_q < x_q);
        sy_neg_d = (y1_q < y_q);
        err_d    = $signed({2'b00, adx}) - $signed({2'b00, ady});
        rem_d    = amax - (SKIP_LAST ? ONE : '0);
        if (SKIP_LAST && (amax == '0)) state_d = S_FIN;
        else                           state_d = S_RUN;
      end
      S_RUN: begin
        if (PIX_READY) begin
          if (rem_q == '0) begin
            state_d = S_FIN;
          end else begin
            err_d = err_step;
            rem_d = rem_q - ONE;
            if (step_x) x_d = x_step;
            if (step_y) y_d = y_step;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      rem_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      rem_q    <= rem_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      err_q    <= err_d;
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign PIX_VALID = (state_q == S_RUN);
  assign PIX_LAST  = (state_q == S_RUN) && (rem_q == '0);
  assign DONE      = (state_q == S_FIN);
  assign PIX_X     = x_q;
  assign PIX_Y     = y_q;

endmodule

// File: tb/tb_line_raster_stream.sv
// tb/tb_line_raster_stream.sv - Directed and random line checks against a pixel-list model.
// Instance 0 plots the endpoint, instance 1 suppresses it.
module tb_line_raster_stream;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic [1:0]   start;
  logic [W-1:0] x0, y0, x1, y1;
  logic         ready;
  logic [1:0]   busy, valid, last, done;
  logic [W-1:0] px [2];
  logic [W-1:0] py [2];

  int n_cmp = 0;
  int n_err = 0;

  line_raster_stream #(.COORD_W(W), .SKIP_LAST(1'b0)) dut0 (
    .ACLK(clk), .ARESETN(resetn), .START(start[0]),
    .X0(x0), .Y0(y0), .X1(x1), .Y1(y1),
    .BUSY(busy[0]), .PIX_X(px[0]), .PIX_Y(py[0]), .PIX_VALID(valid[0]),
    .PIX_READY(ready), .PIX_LAST(last[0]), .DONE(done[0])
  );

  line_raster_stream #(.COORD_W(W), .SKIP_LAST(1'b1)) dut1 (
    .ACLK(clk), .ARESETN(resetn), .START(start[1]),
    .X0(x0), .Y0(y0), .X1(x1), .Y1(y1),
    .BUSY(busy[1]), .PIX_X(px[1]), .PIX_Y(py[1]), .PIX_VALID(valid[1]),
    .PIX_READY(ready), .PIX_LAST(last[1]), .DONE(done[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: textbook Bresenham walk terminated by reaching the endpoint
  task automatic run_line(input int sel, input int ax0, input int ay0, input int ax1,
                          input int ay1, input int rmode, input bit inject);
    int ex[$];
    int ey[$];
    int x, y, dx, dy, sx, sy, err, e2, n, idx, k, fv_k, lx_k;
    bit rdy, stalled, finished;
    logic [W-1:0] hx, hy;
    logic hl;
    x = ax0; y = ay0;
    dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx = (ax1 < ax0) ? -1 : 1;
    sy = (ay1 < ay0) ? -1 : 1;
    err = dx + dy;
    forever begin
      ex.push_back(x); ey.push_back(y);
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    if (sel == 1) begin void'(ex.pop_back()); void'(ey.pop_back()); end
    n = ex.size(); idx = 0; fv_k = -1; lx_k = -1; stalled = 0; finished = 0;
    hx = '0; hy = '0; hl = 1'b0;

    @(negedge clk);
    x0 = ax0[W-1:0]; y0 = ay0[W-1:0]; x1 = ax1[W-1:0]; y1 = ay1[W-1:0];
    start[sel] = 1'b1;
    ready = 1'b1;
    for (k = 1; k <= 4000 && !finished; k++) begin
      @(negedge clk);
      start = 2'b00;
      if (k == 1) begin
        check("setup_busy", busy[sel], 1);
        check("setup_valid", valid[sel], 0);
      end
      if (stalled) begin
        check("stall_valid", valid[sel], 1);
        check("stall_x", px[sel], hx);
        check("stall_y", py[sel], hy);
        check("stall_last", last[sel], hl);
      end
      stalled = 0;
      if (done[sel]) begin
        check("done_count", idx, n);
        check("done_cycle", k, (n > 0) ? lx_k + 1 : 2);
        check("done_busy", busy[sel], 1);
        check("done_valid", valid[sel], 0);
        finished = 1;
      end else if (valid[sel]) begin
        if (fv_k < 0) begin
          fv_k = k;
          check("first_valid_cycle", k, 2);
        end
        rdy = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        ready = rdy;
        if (rdy) begin
          if (idx < n) begin
            check("pix_x", px[sel], ex[idx]);
            check("pix_y", py[sel], ey[idx]);
            check("pix_last", last[sel], (idx == n - 1) ? 1 : 0);
          end else begin
            check("extra_pixel", idx, n - 1);
          end
          idx++;
          lx_k = k;
        end else begin
          stalled = 1;
          hx = px[sel]; hy = py[sel]; hl = last[sel];
        end
      end else begin
        ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (inject && k == 4) begin
        start[sel] = 1'b1;
        x0 = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); y1 = W'($urandom);
      end
    end
    if (!finished) check("timeout", 0, 1);
    @(negedge clk);
    check("post_busy", busy[sel], 0);
    check("post_done", done[sel], 0);
    check("post_valid", valid[sel], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 2'b00; ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_busy", busy[s], 0);
      check("rst_valid", valid[s], 0);
      check("rst_last", last[s], 0);
      check("rst_done", done[s], 0);
      check("rst_x", px[s], 0);
      check("rst_y", py[s], 0);
    end
    resetn = 1'b1;

    run_line(0, 0, 0, 5, 2, 0, 1'b0);
    run_line(0, 3, 7, 3, 2, 0, 1'b0);
    run_line(0, 7, 3, 2, 3, 0, 1'b0);
    run_line(0, 9, 9, 9, 9, 0, 1'b0);
    run_line(1, 9, 9, 9, 9, 0, 1'b0);
    run_line(1, 0, 0, 5, 2, 0, 1'b0);
    run_line(0, 0, 0, 5, 2, 1, 1'b0);
    run_line(0, 0, 0, 5, 2, 1, 1'b0);
    run_line(0, 255, 0, 0, 255, 0, 1'b0);
    run_line(1, 0, 255, 255, 0, 1, 1'b0);
    run_line(0, 0, 0, 255, 255, 0, 1'b0);
    run_line(0, 2, 1, 30, 12, 0, 1'b1);
    run_line(1, 40, 3, 10, 20, 0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      int lim;
      lim = (i % 2 == 0) ? 15 : 255;
      run_line(int'($urandom_range(0, 1)), int'($urandom_range(0, lim)),
               int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
               int'($urandom_range(0, lim)), 1, 1'b0);
    end

    // Abort a line with reset while its third pixel is on the bus
    @(negedge clk);
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd20; y1 = 8'd7;
    start[0] = 1'b1; ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 2'b00;
    end
    check("abort_pre_valid", valid[0], 1);
    check("abort_pre_x", px[0], 2);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_busy", busy[0], 0);
    check("abort_valid", valid[0], 0);
    check("abort_done", done[0], 0);
    check("abort_x", px[0], 0);
    resetn = 1'b1;
    @(negedge clk);
    check("abort_after_done", done[0], 0);
    check("abort_after_busy", busy[0], 0);

    run_line(0, 6, 1, 0, 4, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
